// File: rtl/gate_check_pkg.sv
// ============================================================================
// Module      : gate_check_pkg
// Description : Shared types and constants for the two-input gate checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_GATES = 5;

    localparam int GATE_NOT  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_AND  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_XOR  = 4;

    // Four {b,a} vectors packed LSB-first: 00, 01, 10, 11
    localparam logic [7:0] VEC_ORDER = 8'b11_10_01_00;

    function automatic logic [1:0] vecAt(input logic [1:0] idx);
        return VEC_ORDER[{idx, 1'b0} +: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_expect.sv
// ============================================================================
// Module      : gate_expect
// Description : Golden model of the two-input gate layer, in err_mask order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_expect
    import gate_check_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    assign expected[GATE_NOT]  = ~a;
    assign expected[GATE_OR]   = a | b;
    assign expected[GATE_AND]  = a & b;
    assign expected[GATE_NAND] = ~(a & b);
    assign expected[GATE_XOR]  = a ^ b;

endmodule

`default_nettype wire

// File: rtl/gate_checker.sv
// ============================================================================
// Module      : gate_checker
// Description : Drives the gate truth table, samples results, reports errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       not_in,
    input  logic       or_in,
    input  logic       and_in,
    input  logic       nand_in,
    input  logic       xor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_mask,
    output logic       err_valid,
    output logic [1:0] err_vec
);

    localparam logic [7:0] C_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t                 r_state;
    logic [1:0]             r_idx;
    logic [7:0]             r_cnt;
    logic [NUM_GATES-1:0]   w_expected;
    logic [NUM_GATES-1:0]   w_actual;
    logic [NUM_GATES-1:0]   w_mismatch;

    gate_expect u_gateExpect (
        .a        (a),
        .b        (b),
        .expected (w_expected)
    );

    assign w_actual   = {xor_in, nand_in, and_in, or_in, not_in};
    assign w_mismatch = w_actual ^ w_expected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= 8'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 5'd0;
            err_valid <= 1'b0;
            err_vec   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        err_mask  <= 5'd0;
                        err_valid <= 1'b0;
                        err_vec   <= 2'd0;
                        pass      <= 1'b0;
                        r_idx     <= 2'd0;
                        busy      <= 1'b1;
                        r_state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    {b, a}  <= vecAt(r_idx);
                    r_cnt   <= C_SETTLE_LOAD;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    err_mask <= err_mask | w_mismatch;
                    if ((|w_mismatch) && !err_valid) begin
                        err_valid <= 1'b1;
                        err_vec   <= {b, a};
                    end
                    if (r_idx == 2'd3) begin
                        // Pass must include this final vector's mismatches
                        done    <= 1'b1;
                        pass    <= ~(|(err_mask | w_mismatch));
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= DRIVE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
